matmul_host_driver: RTL and testbench

Host-side driver and result checker for the 2x2 signed matrix-multiplier tile. It accepts operand pairs from an upstream source over a valid/ready handshake, drives the multiplier's `ui_in`/`uio_in`/`ena` pins, and waits a fixed latency. It then captures the packed C result from `uo_out`/`uio_out` and compares it against an internal reference model. The result, a mismatch flag and a running error count are presented downstream. It sits between the on-chip stimulus source and the multiplier tile, one transaction in flight at a time.

---
 rtl/matmul_host_driver.sv | 100 ++++++++++
 tb/tb_matmul_host_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_host_driver.sv
// matmul_host_driver: feeds operand pairs to the 2x2 matmul tile and checks its C result against a reference model.
module matmul_host_driver #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_a,
    input  logic [7:0]  s_b,
    output logic [7:0]  mm_ui_in,
    output logic [7:0]  mm_uio_in,
    output logic        mm_ena,
    input  logic [7:0]  mm_uo_out,
    input  logic [7:0]  mm_uio_out,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_c,
    output logic        m_mismatch,
    output logic [7:0]  err_count,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] w_exp;
    logic [15:0] w_c;
    logic        w_mis;
    function automatic logic [3:0] dot(input logic [1:0] p0, q0, p1, q1);
        logic signed [4:0] e0, f0, e1, f1, s;
        e0 = {{3{p0[1]}}, p0};
        f0 = {{3{q0[1]}}, q0};
        e1 = {{3{p1[1]}}, p1};
        f1 = {{3{q1[1]}}, q1};
        s  = e0 * f0 + e1 * f1;
        return s[3:0];
    endfunction
    // Operand registers stay constant throughout RUN, so the model reads them directly.
    assign w_exp = {dot(mm_ui_in[7:6], mm_uio_in[7:6], mm_ui_in[5:4], mm_uio_in[3:2]),
                    dot(mm_ui_in[7:6], mm_uio_in[5:4], mm_ui_in[5:4], mm_uio_in[1:0]),
                    dot(mm_ui_in[3:2], mm_uio_in[7:6], mm_ui_in[1:0], mm_uio_in[3:2]),
                    dot(mm_ui_in[3:2], mm_uio_in[5:4], mm_ui_in[1:0], mm_uio_in[1:0])};
    assign w_c   = {mm_uo_out, mm_uio_out};
    assign w_mis = w_exp != w_c;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            s_ready    <= 1'b0;
            mm_ui_in   <= '0;
            mm_uio_in  <= '0;
            mm_ena     <= 1'b0;
            m_valid    <= 1'b0;
            m_c        <= '0;
            m_mismatch <= 1'b0;
            err_count  <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        mm_ui_in  <= s_a;
                        mm_uio_in <= s_b;
                        mm_ena    <= 1'b1;
                        r_cnt     <= LAT_M1;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (r_cnt == 4'd0) begin
                        m_c        <= w_c;
                        m_mismatch <= w_mis;
                        if (w_mis && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        mm_ena    <= 1'b0;
                        mm_ui_in  <= '0;
                        mm_uio_in <= '0;
                        m_valid   <= 1'b1;
                        r_state   <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_host_driver.sv
// tb_matmul_host_driver: directed checks of handshake timing, reference compare, saturation, back-pressure and reset abort.
module tb_matmul_host_driver;
    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, mm_ena, m_valid, m_ready, m_mismatch, busy;
    logic [7:0]  s_a, s_b, mm_ui_in, mm_uio_in, mm_uo_out, mm_uio_out, err_count;
    logic [15:0] m_c;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t_acc [4];

    matmul_host_driver #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mm_ui_in(mm_ui_in), .mm_uio_in(mm_uio_in), .mm_ena(mm_ena),
        .mm_uo_out(mm_uo_out), .mm_uio_out(mm_uio_out), .m_valid(m_valid), .m_ready(m_ready),
        .m_c(m_c), .m_mismatch(m_mismatch), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers one pair from IDLE, plays the multiplier returning ret, and stops in the first HOLD cycle.
    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ret);
        s_a = a;
        s_b = b;
        {mm_uo_out, mm_uio_out} = ret;
        m_ready = 1'b1;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 20 && !m_valid; k++) tick();
        chk("txn_done", 16'(m_valid), 16'd1);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_a = '0; s_b = '0;
        mm_uo_out = '0; mm_uio_out = '0;
        tick();
        tick();
        chk("rst_s_ready", 16'(s_ready), 16'd0);
        chk("rst_m_valid", 16'(m_valid), 16'd0);
        chk("rst_ena", 16'(mm_ena), 16'd0);
        chk("rst_err", 16'(err_count), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_m_c", m_c, 16'h0000);
        rst = 1'b0;
        tick();
        chk("idle_s_ready", 16'(s_ready), 16'd1);
        chk("idle_ena", 16'(mm_ena), 16'd0);

        // First vector, stepped cycle by cycle, then back-pressure.
        s_a = 8'h6E; s_b = 8'hD5; {mm_uo_out, mm_uio_out} = 16'hDFFD; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("run1_ena", 16'(mm_ena), 16'd1);
        chk("run1_ui", 16'(mm_ui_in), 16'h6E);
        chk("run1_uio", 16'(mm_uio_in), 16'hD5);
        chk("run1_s_ready", 16'(s_ready), 16'd0);
        chk("run1_busy", 16'(busy), 16'd1);
        tick();
        chk("run2_ena", 16'(mm_ena), 16'd1);
        chk("run2_m_valid", 16'(m_valid), 16'd0);
        tick();
        chk("hold_ena", 16'(mm_ena), 16'd0);
        chk("hold_ui", 16'(mm_ui_in), 16'h00);
        chk("hold_m_valid", 16'(m_valid), 16'd1);
        chk("v1_m_c", m_c, 16'hDFFD);
        chk("v1_mis", 16'(m_mismatch), 16'd0);
        chk("v1_err", 16'(err_count), 16'd0);
        s_valid = 1'b1; s_a = 8'hAA; s_b = 8'hAA; {mm_uo_out, mm_uio_out} = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_m_valid", 16'(m_valid), 16'd1);
            chk("bp_m_c", m_c, 16'hDFFD);
            chk("bp_s_ready", 16'(s_ready), 16'd0);
            chk("bp_ena", 16'(mm_ena), 16'd0);
        end
        m_ready = 1'b1;
        tick();
        chk("rel_m_valid", 16'(m_valid), 16'd0);
        chk("rel_busy", 16'(busy), 16'd0);
        chk("rel_s_ready", 16'(s_ready), 16'd1);
        chk("rel_ena", 16'(mm_ena), 16'd0);
        s_valid = 1'b0;

        txn(8'hAA, 8'hAA, 16'h8888);
        chk("wrap_m_c", m_c, 16'h8888);
        chk("wrap_mis", 16'(m_mismatch), 16'd0);
        tick();

        txn(8'h6E, 8'hD5, 16'h0000);
        chk("mis_flag", 16'(m_mismatch), 16'd1);
        chk("mis_err1", 16'(err_count), 16'd1);
        tick();
        txn(8'h6E, 8'hD5, 16'hDFFC);
        chk("mis_lsb_flag", 16'(m_mismatch), 16'd1);
        chk("mis_err2", 16'(err_count), 16'd2);
        tick();
        for (int i = 0; i < 252; i++) begin
            txn(8'h6E, 8'hD5, 16'h0000);
            tick();
        end
        chk("err_254", 16'(err_count), 16'd254);
        txn(8'h6E, 8'hD5, 16'h0000);
        chk("err_255", 16'(err_count), 16'd255);
        tick();
        for (int i = 0; i < 45; i++) begin
            txn(8'h6E, 8'hD5, 16'h0000);
            tick();
        end
        chk("err_sat", 16'(err_count), 16'hFF);
        chk("sat_mis", 16'(m_mismatch), 16'd1);

        // Reset during the second RUN cycle.
        s_a = 8'h6E; s_b = 8'hD5; {mm_uo_out, mm_uio_out} = 16'hDFFD; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("abort_in_run", 16'(mm_ena), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ena", 16'(mm_ena), 16'd0);
        chk("abort_m_valid", 16'(m_valid), 16'd0);
        chk("abort_err", 16'(err_count), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        tick();
        chk("abort_m_valid2", 16'(m_valid), 16'd0);
        chk("post_rst_s_ready", 16'(s_ready), 16'd1);
        txn(8'h6E, 8'hD5, 16'hDFFD);
        chk("post_rst_m_c", m_c, 16'hDFFD);
        chk("post_rst_mis", 16'(m_mismatch), 16'd0);
        chk("post_rst_err", 16'(err_count), 16'd0);
        tick();

        // Back-to-back stream with both handshakes held high.
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 20 && !s_ready; k++) tick();
            chk("tp_s_ready", 16'(s_ready), 16'd1);
            case (i)
                0: begin s_a = 8'h6E; s_b = 8'hD5; {mm_uo_out, mm_uio_out} = 16'hDFFD; end
                1: begin s_a = 8'hAA; s_b = 8'hAA; {mm_uo_out, mm_uio_out} = 16'h8888; end
                2: begin s_a = 8'h40; s_b = 8'h1B; {mm_uo_out, mm_uio_out} = 16'h0100; end
                default: begin s_a = 8'h41; s_b = 8'hD5; {mm_uo_out, mm_uio_out} = 16'hF111; end
            endcase
            t_acc[i] = cyc;
            tick();
            for (int k = 0; k < 20 && !m_valid; k++) tick();
            case (i)
                0: chk("tp_c0", m_c, 16'hDFFD);
                1: chk("tp_c1", m_c, 16'h8888);
                2: chk("tp_c2", m_c, 16'h0100);
                default: chk("tp_c3", m_c, 16'hF111);
            endcase
            chk("tp_mis", 16'(m_mismatch), 16'd0);
            tick();
        end
        s_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("tp_period", 16'(t_acc[i] - t_acc[i-1]), 16'd4);
        chk("tp_err", 16'(err_count), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
